// File: rtl/tick_pkg.sv
// Shared constants for the tick_counter slice: default sizes, direction encoding
// and the counter operation selected each cycle.
package tick_pkg;

  localparam int TICK_WIDTH           = 8;
  localparam int TICK_MAX_COUNT       = 9;
  localparam int TICK_DEBOUNCE_CYCLES = 16;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } count_op_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for slow_in, optional debounce filter (TICK_COUNTER_DEBOUNCE_EN)
// and rising-edge detector. rise is combinational so the counter updates with tick.
module sync_edge_detect
  import tick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = TICK_DEBOUNCE_CYCLES
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic slow_in,
  output logic rise,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic tick_q, tick_d;
  logic level;

`ifdef TICK_COUNTER_DEBOUNCE_EN
  localparam int STAB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [STAB_W-1:0] stab_q, stab_d;
  logic              filt_q, filt_d;

  // The run length restarts whenever sync2 agrees with the filtered level again.
  always_comb begin
    stab_d = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (stab_q == STAB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        stab_d = stab_q + STAB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stab_q <= '0;
      filt_q <= 1'b0;
    end else begin
      stab_q <= stab_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  logic debounce_unused;
  assign debounce_unused = (DEBOUNCE_CYCLES > 0);
  assign level           = sync2_q;
`endif

  always_comb begin
    sync1_d = slow_in;
    sync2_d = sync1_q;
    prev_d  = level;
    rise    = level & ~prev_q;
    tick_d  = rise;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tick_counter.sv
// Modulo up/down counter advanced by rising edges of a slow asynchronous input.
// Build with TICK_COUNTER_DEBOUNCE_EN to insert the debounce filter before edge detection.
module tick_counter
  import tick_pkg::*;
#(
  parameter int               WIDTH           = TICK_WIDTH,
  parameter logic [WIDTH-1:0] MAX_COUNT       = WIDTH'(TICK_MAX_COUNT),
  parameter int               DEBOUNCE_CYCLES = TICK_DEBOUNCE_CYCLES
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_in,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic             rise;
  count_op_e        op;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  sync_edge_detect #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_edge_detect (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .slow_in(slow_in),
    .rise   (rise),
    .tick   (tick)
  );

  // Load wins over a coincident edge; the edge still shows up on tick.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (rise && en) begin
      op = (up == DIR_UP) ? OP_INC : OP_DEC;
    end
  end

  assign load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    case (op)
      OP_LOAD: count_d = load_clamped;
      OP_INC: begin
        if (count_q == MAX_COUNT) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      OP_DEC: begin
        if (count_q == '0) begin
          count_d = MAX_COUNT;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter (default build): directed scenarios followed by
// randomized slow_in pulses, all compared against a sample-history reference model.
module tb_tick_counter;

  localparam int MAXC = 9;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b1;
  logic       slow_in = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       tick;
  logic [7:0] count;
  logic       wrap;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: the last three slow_in samples seen by the DUT, oldest first.
  bit hist[$];
  int m_count;
  bit m_wrap;
  bit m_edge;

  int step_no;
  int first_tick_at;
  int n_ticks;
  int n_wraps;

  tick_counter #(
    .WIDTH          (8),
    .MAX_COUNT      (8'd9),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .slow_in (slow_in),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .tick    (tick),
    .count   (count),
    .wrap    (wrap)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = '{1'b0, 1'b0, 1'b0};
    m_count = 0;
    m_wrap = 1'b0;
    step_no = 0;
    first_tick_at = 0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic s, input logic e, input logic u, input logic ld,
                      input logic [7:0] lv);
    slow_in = s; en = e; up = u; load = ld; load_val = lv;
    @(posedge clk_in);
    step_no++;
    hist.push_back(s);
    // A rising edge reaches the counter two samples after it was taken.
    m_edge = hist[1] && !hist[0];
    void'(hist.pop_front());
    m_wrap = 1'b0;
    if (ld) begin
      m_count = (int'(lv) > MAXC) ? MAXC : int'(lv);
    end else if (m_edge && e) begin
      if (u) begin
        m_wrap  = (m_count + 1 > MAXC);
        m_count = (m_count + 1) % (MAXC + 1);
      end else begin
        m_wrap  = (m_count == 0);
        m_count = (m_count + MAXC) % (MAXC + 1);
      end
    end
    #1;
    chk("tick", tick, m_edge);
    chk("count", count, m_count);
    chk("wrap", wrap, m_wrap);
    if (tick) begin
      n_ticks++;
      if (first_tick_at == 0) first_tick_at = step_no;
      $display("tick %0d: count=%0d wrap=%0d en=%0d up=%0d load=%0d", n_ticks, count, wrap, e, u, ld);
    end
    if (wrap) n_wraps++;
  endtask

  task automatic pulse(input int h, input int l, input logic e, input logic u,
                       input int ld_idx, input logic [7:0] lv);
    for (int i = 0; i < h; i++) step(1'b1, e, u, (i == ld_idx), (i == ld_idx) ? lv : 8'd0);
    for (int i = 0; i < l; i++) step(1'b0, e, u, 1'b0, 8'd0);
  endtask

  task automatic rand_pulse();
    int h;
    int l;
    h = $urandom_range(2, 6);
    l = $urandom_range(2, 6);
    for (int i = 0; i < h + l; i++) begin
      step((i < h), ($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)));
    end
  endtask

  // Reset is asserted between edges and must clear the outputs before the next edge.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, "_count"}, count, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_wrap"}, wrap, 0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
    $display("reset %s released", tag);
  endtask

  int saved_count;
  int saved_ticks;

  initial begin
    model_reset();
    #1;
    async_reset("init");

    // First edge: held 8 cycles, tick at the 3rd edge, count 0 -> 1.
    n_ticks = 0; n_wraps = 0;
    pulse(8, 4, 1'b1, 1'b1, -1, 8'd0);
    chk("first_tick_edge", first_tick_at, 3);
    chk("first_count", count, 1);
    chk("first_ticks", n_ticks, 1);
    chk("first_wraps", n_wraps, 0);

    // Nine more ticks up: 2..9 then wrap to 0.
    for (int i = 0; i < 9; i++) pulse(3, 3, 1'b1, 1'b1, -1, 8'd0);
    chk("ten_up_count", count, 0);
    chk("ten_up_wraps", n_wraps, 1);
    chk("ten_up_ticks", n_ticks, 10);

    // Down from 0 wraps to MAX_COUNT.
    pulse(3, 3, 1'b1, 1'b0, -1, 8'd0);
    chk("down_wrap_count", count, MAXC);
    chk("down_wrap_wraps", n_wraps, 2);

    // Load 12 on the tick cycle: clamped to 9, tick not applied.
    saved_ticks = n_ticks;
    pulse(3, 3, 1'b1, 1'b1, 2, 8'd12);
    chk("load_clamp_count", count, MAXC);
    chk("load_clamp_tick", n_ticks, saved_ticks + 1);

    // Load 5 ahead of the edge, then the tick increments it.
    pulse(3, 3, 1'b1, 1'b1, 0, 8'd5);
    chk("load_then_tick", count, 6);

    // Disabled counter still emits ticks.
    saved_count = count;
    saved_ticks = n_ticks;
    for (int i = 0; i < 3; i++) pulse(3, 3, 1'b0, 1'b1, -1, 8'd0);
    chk("en0_count", count, saved_count);
    chk("en0_ticks", n_ticks, saved_ticks + 3);

    // Reset mid-count with an edge in flight.
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    async_reset("mid");

    for (int p = 0; p < 300; p++) begin
      rand_pulse();
      if (p == 150) async_reset("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
